// File: rtl/toggle_handshake_rx.sv
// Destination side of a toggle-encoded CDC handshake. It synchronizes the request toggle,
// captures the bundled word, and returns an acknowledge toggle once the word is accepted downstream.
module toggle_handshake_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             rd_clk,
  input  logic             rd_reset,
  input  logic             req_toggle,
  input  logic [WIDTH-1:0] req_data,
  output logic             ack_toggle,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic [15:0]      xfer_count,
  output logic             protocol_err
);

  typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   req_edge;
  logic                   ack_reg, ack_next;
  logic [WIDTH-1:0]       data_reg, data_next;
  logic                   valid_reg, valid_next;
  logic [15:0]            xfer_count_reg, xfer_count_next;
  logic                   err_reg, err_next;

  // Only the last synchronizer stage is considered settled enough to feed logic.
  assign req_edge = sync_reg[SYNC_STAGES-1] ^ hist_reg;

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], req_toggle};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      state_reg      <= IDLE;
      ack_reg        <= 1'b0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      xfer_count_reg <= 16'd0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ack_reg        <= ack_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      xfer_count_reg <= xfer_count_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ack_next        = ack_reg;
    data_next       = data_reg;
    valid_next      = valid_reg;
    xfer_count_next = xfer_count_reg;
    err_next        = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_edge) begin
          data_next  = req_data;
          valid_next = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        // A new request while a word is pending is dropped, even if this cycle accepts.
        if (req_edge) err_next = 1'b1;
        if (valid_reg && rd_ready) begin
          ack_next        = ~ack_reg;
          valid_next      = 1'b0;
          xfer_count_next = xfer_count_reg + 16'd1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ack_toggle   = ack_reg;
  assign rd_data      = data_reg;
  assign rd_valid     = valid_reg;
  assign busy         = (state_reg == VALID);
  assign xfer_count   = xfer_count_reg;
  assign protocol_err = err_reg;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed bench for toggle_handshake_rx: stimulus pushes expected words into a queue,
// and a monitor pops and compares them on every downstream accept.
module tb_toggle_handshake_rx;

  logic        rd_clk = 1'b0;
  logic        rd_reset;
  logic        req_toggle;
  logic [7:0]  req_data;
  logic        ack_toggle;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic [15:0] xfer_count;
  logic        protocol_err;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [7:0] exp_q[$];

  toggle_handshake_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .rd_clk       (rd_clk),
    .rd_reset     (rd_reset),
    .req_toggle   (req_toggle),
    .req_data     (req_data),
    .ack_toggle   (ack_toggle),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .xfer_count   (xfer_count),
    .protocol_err (protocol_err)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_ack(input logic exp, input string name);
    for (int i = 0; i < 20; i++) begin
      if (ack_toggle == exp) break;
      tick();
    end
    chk(name, {31'd0, ack_toggle}, {31'd0, exp});
  endtask

  // Scoreboard monitor: each accept must match the oldest outstanding word.
  always @(negedge rd_clk) begin
    if (!rd_reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_accept: got %0h expected none", rd_data);
      end else begin
        logic [7:0] exp_w;
        exp_w = exp_q.pop_front();
        chk("accept_data", {24'd0, rd_data}, {24'd0, exp_w});
        $display("accept data=%0h expected=%0h count=%0d", rd_data, exp_w, xfer_count);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rd_reset   = 1'b1;
    req_toggle = 1'b0;
    req_data   = 8'h00;
    rd_ready   = 1'b0;
    tick(); tick();
    chk("reset_valid", {31'd0, rd_valid}, 0);
    chk("reset_ack", {31'd0, ack_toggle}, 0);
    chk("reset_count", {16'd0, xfer_count}, 0);
    chk("reset_err", {31'd0, protocol_err}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_data", {24'd0, rd_data}, 0);
    rd_reset = 1'b0;
    tick();

    // Single transfer with rd_ready held high.
    rd_ready = 1'b1; req_data = 8'hA5; req_toggle = 1'b1; exp_q.push_back(8'hA5);
    tick(); tick();
    chk("t1_valid_early", {31'd0, rd_valid}, 0);
    tick();
    chk("t1_valid", {31'd0, rd_valid}, 1);
    chk("t1_data", {24'd0, rd_data}, 32'hA5);
    chk("t1_busy", {31'd0, busy}, 1);
    tick();
    chk("t1_ack", {31'd0, ack_toggle}, 1);
    chk("t1_count", {16'd0, xfer_count}, 1);
    chk("t1_valid_fall", {31'd0, rd_valid}, 0);

    // Backpressure for 10 cycles.
    rd_ready = 1'b0; req_data = 8'h3C; req_toggle = 1'b0; exp_q.push_back(8'h3C);
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", {31'd0, rd_valid}, 1);
      chk("t2_hold_data", {24'd0, rd_data}, 32'h3C);
      chk("t2_hold_ack", {31'd0, ack_toggle}, 1);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    chk("t2_ack", {31'd0, ack_toggle}, 0);
    chk("t2_count", {16'd0, xfer_count}, 2);

    // Back-to-back transfers, source waiting on ack each time.
    for (int i = 1; i <= 4; i++) begin
      req_data = 8'(i);
      req_toggle = ~req_toggle;
      exp_q.push_back(8'(i));
      tick();
      wait_ack(req_toggle, "t3_ack_wait");
    end
    tick();
    chk("t3_ack_final", {31'd0, ack_toggle}, 0);
    chk("t3_count", {16'd0, xfer_count}, 6);
    chk("t3_err", {31'd0, protocol_err}, 0);

    // Protocol violation: second flip while a word is pending.
    rd_ready = 1'b0; req_data = 8'h77; req_toggle = 1'b1; exp_q.push_back(8'h77);
    tick(); tick(); tick();
    req_data = 8'h88; req_toggle = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t4_err", {31'd0, protocol_err}, 1);
    chk("t4_data", {24'd0, rd_data}, 32'h77);
    chk("t4_valid", {31'd0, rd_valid}, 1);
    chk("t4_ack_hold", {31'd0, ack_toggle}, 0);
    rd_ready = 1'b1;
    tick();
    chk("t4_ack", {31'd0, ack_toggle}, 1);
    tick(); tick(); tick(); tick();
    chk("t4_no_extra_valid", {31'd0, rd_valid}, 0);
    chk("t4_single_ack", {31'd0, ack_toggle}, 1);
    chk("t4_count", {16'd0, xfer_count}, 7);
    chk("t4_err_sticky", {31'd0, protocol_err}, 1);

    // Reset while a word is pending; that word is never accepted.
    rd_ready = 1'b0; req_data = 8'h99; req_toggle = 1'b1;
    tick(); tick(); tick();
    chk("t5_pre_valid", {31'd0, rd_valid}, 1);
    #2;
    rd_reset = 1'b1; req_toggle = 1'b0;
    #1;
    chk("t5_valid", {31'd0, rd_valid}, 0);
    chk("t5_ack", {31'd0, ack_toggle}, 0);
    chk("t5_count", {16'd0, xfer_count}, 0);
    chk("t5_err", {31'd0, protocol_err}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    tick(); tick();
    rd_reset = 1'b0;
    tick();

    // Counter wrap: preload the count to its maximum, then one more accept.
    force dut.xfer_count_reg = 16'hFFFF;
    #1;
    release dut.xfer_count_reg;
    rd_ready = 1'b1; req_data = 8'h5A; req_toggle = 1'b1; exp_q.push_back(8'h5A);
    tick();
    wait_ack(1'b1, "t6_ack_wait");
    chk("t6_count_wrap", {16'd0, xfer_count}, 0);
    chk("t6_err", {31'd0, protocol_err}, 0);
    tick();
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
